// File: rtl/scarv_soc_pkg.sv
// Shared types and sizes for the SoC BRAM initiator: BRAM port width, response FIFO depth
// and the {error, rdata} response entry layout.
package scarv_soc_pkg;

    localparam int SCARV_SOC_BRAM_AW       = 14;
    localparam int SCARV_SOC_BRAM_RSP_DEPTH = 2;
    localparam int SCARV_SOC_RSP_RDATA_W   = 32;
    localparam int SCARV_SOC_RSP_ERROR_W   = 1;

    typedef struct packed {
        logic [SCARV_SOC_RSP_ERROR_W-1:0] error;
        logic [SCARV_SOC_RSP_RDATA_W-1:0] rdata;
    } bram_rsp_t;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_kind_e;

endpackage

// File: rtl/scarv_soc_bram_initiator_if.sv
// Core/interconnect memory channel seen by the BRAM initiator: one request channel and
// one in-order response channel.
interface scarv_soc_bram_initiator_if;

    // Both channels use strict valid/ready: a beat transfers on a rising clock edge where
    // valid & ready are both high; once valid is raised, the payload holds until it transfers.
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_addr, req_wen, req_strb, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_strb, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/scarv_soc_bram_rsp_fifo.sv
// Two-entry response FIFO holding {error, rdata}. Push and pop may occur in the same
// cycle; the head is a direct read of the oldest entry.
module scarv_soc_bram_rsp_fifo
    import scarv_soc_pkg::*;
(
    input  logic      g_clk,
    input  logic      g_resetn,
    input  logic      push,
    input  bram_rsp_t push_data,
    input  logic      pop,
    output bram_rsp_t head,
    output logic [1:0] count
);

    bram_rsp_t mem [SCARV_SOC_BRAM_RSP_DEPTH];
    logic      wr_ptr;
    logic      rd_ptr;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge g_clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/scarv_soc_bram_initiator.sv
// Bridge from a valid/ready memory channel to one single-port BRAM port, absorbing the
// 1-cycle read latency. Optional address range check: SCARV_SOC_BRAM_ADDR_CHECK_EN.
module scarv_soc_bram_initiator
    import scarv_soc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          AW        = SCARV_SOC_BRAM_AW
) (
    input  logic                    g_clk,
    input  logic                    g_resetn,
    scarv_soc_bram_initiator_if.slave bus,
    output logic                    bram_en,
    output logic [3:0]              bram_we,
    output logic [AW-1:0]           bram_addr,
    output logic [31:0]             bram_wdata,
    input  logic [31:0]             bram_rdata
);

    logic       req_fire;
    logic       in_range;
    logic       pending;
    acc_kind_e  pending_kind;
    logic       pending_err;
    bram_rsp_t  bypass;
    bram_rsp_t  head;
    bram_rsp_t  rsp;
    logic [1:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;

`ifdef SCARV_SOC_BRAM_ADDR_CHECK_EN
    localparam logic [32:0] RANGE_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] RANGE_HI = RANGE_LO + 33'(DEPTH);

    assign in_range = ({1'b0, bus.req_addr} >= RANGE_LO) && ({1'b0, bus.req_addr} < RANGE_HI);
`else
    // Without the check the BRAM simply aliases; base and size only matter to the comparator.
    localparam logic [31:0] UNUSED_CFG = BASE_ADDR ^ 32'(DEPTH);
    logic unused_addr;

    assign unused_addr = ^{bus.req_addr[31:AW], bus.req_addr[1:0], UNUSED_CFG};
    assign in_range    = 1'b1;
`endif

    // Occupancy counts the access in flight at the BRAM, so a full FIFO can never overflow.
    assign bus.req_ready = g_resetn && ((fifo_count + {1'b0, pending}) < 2'd2);
    assign req_fire      = bus.req_valid & bus.req_ready;

    assign bram_en    = req_fire & in_range;
    assign bram_we    = (bram_en & bus.req_wen) ? bus.req_strb : 4'b0000;
    assign bram_addr  = {bus.req_addr[AW-1:2], 2'b00};
    assign bram_wdata = bus.req_wdata;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            pending      <= 1'b0;
            pending_kind <= ACC_READ;
            pending_err  <= 1'b0;
        end else begin
            pending      <= req_fire;
            pending_kind <= bus.req_wen ? ACC_WRITE : ACC_READ;
            pending_err  <= req_fire & ~in_range;
        end
    end

    always_comb begin
        bypass       = '0;
        bypass.error = pending_err;
        if (!pending_err && pending_kind == ACC_READ) bypass.rdata = bram_rdata;
    end

    assign fifo_empty = (fifo_count == 2'd0);
    assign fifo_pop   = ~fifo_empty & bus.rsp_ready;
    // bram_rdata is only valid this cycle, so an unconsumed bypass entry is captured now.
    assign fifo_push  = pending & ~(fifo_empty & bus.rsp_ready);

    scarv_soc_bram_rsp_fifo u_rsp_fifo (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .push      (fifo_push),
        .push_data (bypass),
        .pop       (fifo_pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign rsp           = fifo_empty ? bypass : head;
    assign bus.rsp_valid = ~fifo_empty | pending;
    assign bus.rsp_rdata = rsp.rdata;
    assign bus.rsp_error = rsp.error;

endmodule

// File: tb/tb_scarv_soc_bram_initiator.sv
// Self-checking bench for scarv_soc_bram_initiator: BRAM model, shadow memory scoreboard,
// directed scenarios then a randomised mix with random response back-pressure.
module tb_scarv_soc_bram_initiator;

    localparam int          AW    = 14;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic g_clk = 1'b0;
    logic g_resetn;
    always #5 g_clk = ~g_clk;

    scarv_soc_bram_initiator_if bus ();

    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata;
    logic [31:0]   bram_rdata;

    scarv_soc_bram_initiator #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .bus        (bus.slave),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    // BRAM model: byte writes, registered read, one cycle latency.
    logic [31:0] bram_mem [256];
    logic [31:0] exp_mem  [256];

    always @(posedge g_clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram_mem[bram_addr[9:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
            bram_rdata <= bram_mem[bram_addr[9:2]];
        end
    end

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [32:0] exp_q [$];
    int          acc_q [$];
    bit          chk_lat = 0;
    bit          rand_rdy = 0;
    bit          hold_v = 0;
    logic [32:0] held;
    logic [32:0] last_rsp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] addr);
`ifdef SCARV_SOC_BRAM_ADDR_CHECK_EN
        return (addr >= BASE) && (addr < BASE + DEPTH);
`else
        return (addr == addr);
`endif
    endfunction

    always @(posedge g_clk) cyc++;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge g_clk) begin
        logic [32:0] e;
        int          a;
        bit          ok;
        logic [7:0]  idx;
        if (!g_resetn) begin
            exp_q.delete();
            acc_q.delete();
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("rsp_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
                check("rsp_hold_data", bus.rsp_rdata, held[31:0]);
                check("rsp_hold_error", {31'b0, bus.rsp_error}, {31'b0, held[32]});
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                last_rsp = {bus.rsp_error, bus.rsp_rdata};
                if (exp_q.size() == 0) begin
                    check("stale_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, e[31:0]);
                    check("rsp_error", {31'b0, bus.rsp_error}, {31'b0, e[32]});
                    if (chk_lat) check("rsp_latency", cyc - a, 32'd1);
                end
            end
            if (bus.rsp_valid && !bus.rsp_ready) begin
                hold_v = 1;
                held   = {bus.rsp_error, bus.rsp_rdata};
            end else begin
                hold_v = 0;
            end
            if (chk_lat && bus.req_valid) check("burst_ready", {31'b0, bus.req_ready}, 32'd1);
            if (bus.req_valid && bus.req_ready) begin
                ok  = in_rng(bus.req_addr);
                idx = bus.req_addr[9:2];
                check("bram_en", {31'b0, bram_en}, {31'b0, ok});
                check("bram_we", {28'b0, bram_we}, (ok && bus.req_wen) ? {28'b0, bus.req_strb} : 32'd0);
                if (ok) check("bram_addr", {18'b0, bram_addr}, {18'b0, bus.req_addr[AW-1:2], 2'b00});
                if (ok && bus.req_wen) check("bram_wdata", bram_wdata, bus.req_wdata);
                if (!ok) begin
                    e = {1'b1, 32'h0};
                end else if (bus.req_wen) begin
                    e = '0;
                    for (int b = 0; b < 4; b++)
                        if (bus.req_strb[b]) exp_mem[idx][8*b +: 8] = bus.req_wdata[8*b +: 8];
                end else begin
                    e = {1'b0, exp_mem[idx]};
                end
                exp_q.push_back(e);
                acc_q.push_back(cyc);
            end else begin
                check("bram_idle", {31'b0, bram_en}, 32'd0);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic do_req(input bit wen, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata);
        bit acc = 0;
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_strb  = strb;
        bus.req_wdata = wdata;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge g_clk);
            acc = bus.req_ready;
            @(posedge g_clk);
            #1;
            if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) check("req_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge g_clk);
            #1;
        end
        @(posedge g_clk);
        #1;
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            bram_mem[i] = v;
            exp_mem[i]  = v;
        end
        g_resetn      = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 32'h10;
        bus.req_strb  = 4'hF;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;

        #12;
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_error", {31'b0, bus.rsp_error}, 32'd0);
        check("rst_bram_en", {31'b0, bram_en}, 32'd0);
        check("rst_bram_we", {28'b0, bram_we}, 32'd0);
        bus.req_valid = 1'b0;
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        // Full write then read back, one-cycle latency.
        chk_lat = 1;
        do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        drain();
        check("wr_rd_value", last_rsp[31:0], 32'hDEADBEEF);

        // Partial byte write.
        do_req(1'b1, 32'h20, 4'hF, 32'h11223344);
        do_req(1'b1, 32'h20, 4'b0010, 32'h0000AB00);
        do_req(1'b0, 32'h22, 4'h0, 32'h0);
        drain();
        check("partial_wr", last_rsp[31:0], 32'h1122AB44);

        // Eight back-to-back reads with no bubbles.
        for (int i = 0; i < 8; i++) do_req(1'b0, 32'h40 + 32'(i * 4), 4'h0, 32'h0);
        drain();
        chk_lat = 0;

        // Back-pressure: only two requests may be outstanding.
        bus.rsp_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_wen   = 1'b0;
            bus.req_addr  = (i % 2 == 0) ? 32'h10 : 32'h20;
            @(negedge g_clk);
            if (bus.req_ready) n++;
            @(posedge g_clk);
            #1;
        end
        bus.req_valid = 1'b0;
        check("bp_accepted", n, 32'd2);
        check("bp_ready_low", {31'b0, bus.req_ready}, 32'd0);
        drain();

        // Reset with two buffered responses: nothing stale afterwards.
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        do_req(1'b0, 32'h20, 4'h0, 32'h0);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        @(posedge g_clk);
        #1;
        g_resetn      = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (5) @(posedge g_clk);
        #1;
        check("post_rst_idle", {31'b0, bus.rsp_valid}, 32'd0);

        // Write with no strobes leaves memory untouched.
        do_req(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        drain();
        check("zero_strb", last_rsp[31:0], 32'hDEADBEEF);

        // Range boundary.
        do_req(1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
        do_req(1'b0, 32'h3FC, 4'h0, 32'h0);
        do_req(1'b0, 32'h400, 4'h0, 32'h0);
        drain();
`ifdef SCARV_SOC_BRAM_ADDR_CHECK_EN
        check("oor_error", {31'b0, last_rsp[32]}, 32'd1);
        check("oor_rdata", last_rsp[31:0], 32'h0);
`else
        check("alias_rdata", last_rsp[31:0], 32'hCAFEF00D);
`endif

        // Random mix with random response back-pressure.
        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h7FF)),
                   4'($urandom_range(0, 15)), $urandom);
        end
        rand_rdy = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
